// File: rtl/alu_multicycle.sv
// Multi-cycle ALU: registered outputs with a valid/ready handshake.
// Most opcodes finish one cycle after they are accepted. MUL (shift-add)
// and DIV (restoring) iterate for WIDTH cycles in a shared work register.
module alu_multicycle #(
  parameter  int WIDTH = 32,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  input  logic [4:0]         ALU_Select,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [2*WIDTH-1:0] ALU_Out,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               CarryOut,
  output logic               Zero,
  output logic               Overflow,
  output logic               Error
);

  localparam logic [4:0] OP_ADD  = 5'd0,  OP_SUB  = 5'd1,  OP_MUL  = 5'd2,  OP_DIV  = 5'd3;
  localparam logic [4:0] OP_AND  = 5'd4,  OP_OR   = 5'd5,  OP_XOR  = 5'd6,  OP_NOR  = 5'd7;
  localparam logic [4:0] OP_NAND = 5'd8,  OP_XNOR = 5'd9,  OP_SLL  = 5'd10, OP_SRL  = 5'd11;
  localparam logic [4:0] OP_SRA  = 5'd12, OP_ROL  = 5'd13, OP_ROR  = 5'd14, OP_SLT  = 5'd15;
  localparam logic [4:0] OP_SLTU = 5'd16, OP_NOT  = 5'd17, OP_PASS = 5'd18;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t               state_q, state_d;
  logic [SHW-1:0]       cnt_q, cnt_d;
  logic [4:0]           op_q, op_d;
  logic [WIDTH-1:0]     b_q, b_d;
  logic [2*WIDTH-1:0]   work_q, work_d;
  logic [2*WIDTH-1:0]   out_q, out_d;
  logic                 carry_q, carry_d, ovf_q, ovf_d, err_q, err_d, zero_q, zero_d;

  logic                 accept;
  logic                 load;
  logic [SHW-1:0]       sh;
  logic [WIDTH:0]       add_ext, sub_ext;
  logic [WIDTH-1:0]     sra_res, rol_res, ror_res;
  logic [2*WIDTH-1:0]   op_res;
  logic                 op_c, op_v, op_e;
  logic [WIDTH:0]       mul_sum;
  logic [WIDTH:0]       div_shift, div_diff;
  logic [2*WIDTH-1:0]   step_next;

  assign sh      = B[SHW-1:0];
  assign add_ext = {1'b0, A} + {1'b0, B};
  assign sub_ext = {1'b0, A} - {1'b0, B};
  assign sra_res = $signed(A) >>> sh;
  // Shift by WIDTH yields zero, so a zero rotate amount degenerates cleanly.
  assign rol_res = (A << sh) | (A >> ((SHW+1)'(WIDTH) - {1'b0, sh}));
  assign ror_res = (A >> sh) | (A << ((SHW+1)'(WIDTH) - {1'b0, sh}));

  // Single-cycle datapath, evaluated straight from the request inputs.
  always_comb begin
    op_res = '0;
    op_c   = 1'b0;
    op_v   = 1'b0;
    op_e   = 1'b0;
    case (ALU_Select)
      OP_ADD: begin
        op_res = {{(WIDTH-1){1'b0}}, add_ext};
        op_c   = add_ext[WIDTH];
        op_v   = (A[WIDTH-1] == B[WIDTH-1]) && (add_ext[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SUB: begin
        op_res = {{WIDTH{1'b0}}, sub_ext[WIDTH-1:0]};
        op_c   = sub_ext[WIDTH];
        op_v   = (A[WIDTH-1] != B[WIDTH-1]) && (sub_ext[WIDTH-1] != A[WIDTH-1]);
      end
      OP_MUL:  op_res = '0;  // always iterates, never loaded from here
      OP_DIV: begin          // only loaded from here when B is zero
        op_res = {A, {WIDTH{1'b1}}};
        op_e   = 1'b1;
      end
      OP_AND:  op_res = {{WIDTH{1'b0}}, A & B};
      OP_OR:   op_res = {{WIDTH{1'b0}}, A | B};
      OP_XOR:  op_res = {{WIDTH{1'b0}}, A ^ B};
      OP_NOR:  op_res = {{WIDTH{1'b0}}, ~(A | B)};
      OP_NAND: op_res = {{WIDTH{1'b0}}, ~(A & B)};
      OP_XNOR: op_res = {{WIDTH{1'b0}}, ~(A ^ B)};
      OP_SLL:  op_res = {{WIDTH{1'b0}}, A << sh};
      OP_SRL:  op_res = {{WIDTH{1'b0}}, A >> sh};
      OP_SRA:  op_res = {{WIDTH{1'b0}}, sra_res};
      OP_ROL:  op_res = {{WIDTH{1'b0}}, rol_res};
      OP_ROR:  op_res = {{WIDTH{1'b0}}, ror_res};
      OP_SLT:  op_res = {{(2*WIDTH-1){1'b0}}, $signed(A) < $signed(B)};
      OP_SLTU: op_res = {{(2*WIDTH-1){1'b0}}, A < B};
      OP_NOT:  op_res = {{WIDTH{1'b0}}, ~A};
      OP_PASS: op_res = {{WIDTH{1'b0}}, B};
      default: op_e   = 1'b1;
    endcase
  end

  // One iteration of MUL or DIV. Both keep {high, low} in work_q:
  // MUL holds {partial product, remaining multiplier bits},
  // DIV holds {partial remainder, dividend bits shifting into quotient}.
  always_comb begin
    mul_sum   = {1'b0, work_q[2*WIDTH-1:WIDTH]} + (work_q[0] ? {1'b0, b_q} : '0);
    div_shift = work_q[2*WIDTH-1:WIDTH-1];
    div_diff  = div_shift - {1'b0, b_q};
    step_next = {mul_sum, work_q[WIDTH-1:1]};
    if (op_q == OP_DIV) begin
      if (!div_diff[WIDTH]) step_next = {div_diff[WIDTH-1:0], work_q[WIDTH-2:0], 1'b1};
      else                  step_next = {div_shift[WIDTH-1:0], work_q[WIDTH-2:0], 1'b0};
    end
  end

  // Handshake, state transitions and output loading.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    b_d     = b_q;
    work_d  = work_q;
    out_d   = out_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    err_d   = err_q;
    zero_d  = zero_q;
    load    = 1'b0;

    in_ready = (state_q == IDLE) || ((state_q == DONE) && out_ready);
    accept   = in_valid && in_ready;

    case (state_q)
      BUSY: begin
        work_d = step_next;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == SHW'(WIDTH-1)) begin
          state_d = DONE;
          out_d   = step_next;
          carry_d = 1'b0;
          ovf_d   = 1'b0;
          err_d   = 1'b0;
          load    = 1'b1;
        end
      end
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = state_q;
    endcase

    // A new request may start in IDLE or on the same edge DONE is consumed.
    if (accept) begin
      op_d = ALU_Select;
      b_d  = B;
      if ((ALU_Select == OP_MUL) || ((ALU_Select == OP_DIV) && (B != '0))) begin
        state_d = BUSY;
        cnt_d   = '0;
        work_d  = {{WIDTH{1'b0}}, A};
      end else begin
        state_d = DONE;
        out_d   = op_res;
        carry_d = op_c;
        ovf_d   = op_v;
        err_d   = op_e;
        load    = 1'b1;
      end
    end

    if (load) zero_d = (out_d == '0);
  end

  // State and output registers; reset abandons any iteration in progress.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      b_q     <= '0;
      work_q  <= '0;
      out_q   <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      b_q     <= b_d;
      work_q  <= work_d;
      out_q   <= out_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
      err_q   <= err_d;
      zero_q  <= zero_d;
    end
  end

  assign out_valid = (state_q == DONE);
  assign ALU_Out   = out_q;
  assign CarryOut  = carry_q;
  assign Overflow  = ovf_q;
  assign Error     = err_q;
  assign Zero      = zero_q;

endmodule

// File: tb/tb_alu_multicycle.sv
// Testbench for alu_multicycle: directed and random operations compared
// against an arithmetic reference model, plus backpressure and reset abort.
module tb_alu_multicycle;

  localparam int W = 32;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [W-1:0]   A, B;
  logic [4:0]     ALU_Select;
  logic           in_valid, in_ready;
  logic [2*W-1:0] ALU_Out;
  logic           out_valid, out_ready;
  logic           CarryOut, Zero, Overflow, Error;

  int checks = 0;
  int errors = 0;

  alu_multicycle #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .A(A), .B(B), .ALU_Select(ALU_Select),
    .in_valid(in_valid), .in_ready(in_ready), .ALU_Out(ALU_Out),
    .out_valid(out_valid), .out_ready(out_ready), .CarryOut(CarryOut),
    .Zero(Zero), .Overflow(Overflow), .Error(Error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] r;
    logic        c, v, e;
    int          lat;
  } exp_t;

  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;

  // Reference model: plain integer arithmetic on the operation's meaning.
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic [4:0] sel);
    exp_t x;
    longint sa, sb, s;
    int sh;
    logic signed [31:0] sgn;
    logic [31:0] t;
    x.r = '0; x.c = 1'b0; x.v = 1'b0; x.e = 1'b0; x.lat = 1;
    sa = $signed(a); sb = $signed(b); sh = int'(b[4:0]);
    case (sel)
      5'd0: begin
        x.r = {32'b0, a} + {32'b0, b};
        x.c = x.r[32];
        s = sa + sb; x.v = (s > SMAX) || (s < SMIN);
      end
      5'd1: begin
        t = a - b; x.r = {32'b0, t};
        x.c = (a < b);
        s = sa - sb; x.v = (s > SMAX) || (s < SMIN);
      end
      5'd2: begin x.r = {32'b0, a} * {32'b0, b}; x.lat = 33; end
      5'd3: begin
        if (b == 0) begin x.r = {a, 32'hFFFF_FFFF}; x.e = 1'b1; end
        else begin x.r = {a % b, a / b}; x.lat = 33; end
      end
      5'd4:  x.r = {32'b0, a & b};
      5'd5:  x.r = {32'b0, a | b};
      5'd6:  x.r = {32'b0, a ^ b};
      5'd7:  x.r = {32'b0, ~(a | b)};
      5'd8:  x.r = {32'b0, ~(a & b)};
      5'd9:  x.r = {32'b0, ~(a ^ b)};
      5'd10: x.r = {32'b0, a << sh};
      5'd11: x.r = {32'b0, a >> sh};
      5'd12: begin sgn = a; sgn = sgn >>> sh; x.r = {32'b0, sgn}; end
      5'd13: begin t = a; for (int i = 0; i < sh; i++) t = {t[30:0], t[31]}; x.r = {32'b0, t}; end
      5'd14: begin t = a; for (int i = 0; i < sh; i++) t = {t[0], t[31:1]}; x.r = {32'b0, t}; end
      5'd15: x.r = (sa < sb) ? 64'd1 : 64'd0;
      5'd16: x.r = (a < b) ? 64'd1 : 64'd0;
      5'd17: x.r = {32'b0, ~a};
      5'd18: x.r = {32'b0, b};
      default: x.e = 1'b1;
    endcase
    return x;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One complete transaction: request, wait for result, check, consume.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [4:0] sel, input string tag);
    exp_t e;
    int t;
    logic busy_ok;
    e = model(a, b, sel);
    @(negedge clk);
    A = a; B = b; ALU_Select = sel; in_valid = 1'b1; out_ready = 1'b1;
    t = 0;
    while (!in_ready && t < 50) begin @(negedge clk); t++; end
    chk({tag, " accept"}, {63'b0, in_ready}, 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; A = $urandom; B = $urandom; ALU_Select = 5'($urandom);
    t = 0; busy_ok = 1'b1;
    do begin
      @(negedge clk); t++;
      if (!out_valid && in_ready) busy_ok = 1'b0;
    end while (!out_valid && t < 100);
    chk({tag, " latency"}, 64'(t), 64'(e.lat));
    chk({tag, " busy_ready"}, {63'b0, busy_ok}, 64'd1);
    chk({tag, " result"}, ALU_Out, e.r);
    chk({tag, " flags"}, {60'b0, CarryOut, Overflow, Error, Zero},
        {60'b0, e.c, e.v, e.e, (e.r == 64'd0)});
    $display("op sel=%0d a=%h b=%h out=%h c=%b v=%b e=%b z=%b lat=%0d [%s]",
             sel, a, b, ALU_Out, CarryOut, Overflow, Error, Zero, t, tag);
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic [63:0] held;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    A = '0; B = '0; ALU_Select = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("reset out_valid", {63'b0, out_valid}, 64'd0);
    chk("reset in_ready", {63'b0, in_ready}, 64'd1);
    chk("reset ALU_Out", ALU_Out, 64'd0);
    chk("reset flags", {60'b0, CarryOut, Overflow, Error, Zero}, 64'd0);
    rst_n = 1'b1;

    // Opcode sweep on A=0x0A, B=0x02
    for (int s = 0; s <= 18; s++) run_op(32'h0A, 32'h02, 5'(s), "sweep");

    // Arithmetic corner cases
    run_op(32'hFFFF_FFFF, 32'h1, 5'd0, "add_carry");
    run_op(32'h7FFF_FFFF, 32'h1, 5'd0, "add_ovf");
    run_op(32'h8000_0000, 32'h1, 5'd1, "sub_ovf");
    run_op(32'h1, 32'h2, 5'd1, "sub_borrow");
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, "mul_max");
    run_op(32'h0, 32'h1234, 5'd2, "mul_zero");
    run_op(32'hF6, 32'h0, 5'd3, "div_by_zero");
    run_op(32'hF6, 32'h0A, 5'd3, "div");
    run_op(32'h8000_0000, 32'h1F, 5'd12, "sra");
    run_op(32'h8000_0001, 32'h4, 5'd13, "rol");
    run_op(32'h8000_0001, 32'h4, 5'd14, "ror");
    run_op(32'hFFFF_FFFF, 32'h1, 5'd15, "slt_neg");
    run_op(32'h0, 32'h0, 5'd6, "xor_zero");

    // Random operations, small/zero divisors mixed in
    for (int i = 0; i < 40; i++) begin
      ra = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
      run_op(ra, rb, 5'($urandom_range(0, 31)), "random");
    end

    // Backpressure: result held while out_ready is low
    @(negedge clk);
    A = 32'd5; B = 32'd6; ALU_Select = 5'd0; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    A = 32'd9; B = 32'd1; ALU_Select = 5'd1;
    held = 64'd11;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall out_valid", {63'b0, out_valid}, 64'd1);
      chk("stall ALU_Out", ALU_Out, held);
      chk("stall in_ready", {63'b0, in_ready}, 64'd0);
      $display("stall cycle %0d out=%h in_ready=%b", i, ALU_Out, in_ready);
    end
    out_ready = 1'b1;
    #1;
    chk("release in_ready", {63'b0, in_ready}, 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("back2back out_valid", {63'b0, out_valid}, 64'd1);
    chk("back2back ALU_Out", ALU_Out, 64'd8);
    $display("back-to-back sub 9-1 out=%h", ALU_Out);

    // Reset in the middle of a MUL
    @(negedge clk);
    A = 32'h1234; B = 32'h5678; ALU_Select = 5'd2; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("abort out_valid", {63'b0, out_valid}, 64'd0);
    chk("abort ALU_Out", ALU_Out, 64'd0);
    chk("abort in_ready", {63'b0, in_ready}, 64'd1);
    $display("reset during MUL: out_valid=%b out=%h in_ready=%b", out_valid, ALU_Out, in_ready);
    rst_n = 1'b1;
    run_op(32'd3, 32'd4, 5'd0, "post_reset_add");
    run_op(32'h55, 32'hAA, 5'd25, "illegal");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
